dispatch: RTL and testbench

//  In-order issue stage of the Tomasulo core; the consumer end of the instruction-buffer FIFO that fetch fills.

---
 rtl/dispatch.sv | 236 +++++++++++++++++++++++
 tb/tb_dispatch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch.sv
// dispatch: in-order issue stage of the Tomasulo core.
// Pops one instruction per cycle from the instruction buffer, decodes it,
// reads and renames the register file, and issues to the ALU or load
// reservation stations. The CDB is snooped to retire outstanding tags.
// jeq branches are resolved here and redirect fetch with a flush pulse.
module dispatch #(
  parameter int TAG_W = 4,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ib_empty,
  input  logic [31:0]      ib_data_out,
  output logic             ib_pop,
  output logic             ib_flush,
  output logic             branch_taken,
  output logic [15:0]      branch_target,
  input  logic             alu_free,
  input  logic [TAG_W-1:0] alu_free_tag,
  output logic             alu_issue,
  input  logic             ld_free,
  input  logic [TAG_W-1:0] ld_free_tag,
  output logic             ld_issue,
  output logic             op_a_busy,
  output logic [TAG_W-1:0] op_a_tag,
  output logic [15:0]      op_a_val,
  output logic             op_b_busy,
  output logic [TAG_W-1:0] op_b_tag,
  output logic [15:0]      op_b_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_JEQ  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t state, state_next;

  // Register file: busy marks a register waiting on the RS named by tag.
  logic             reg_busy [NREGS];
  logic [TAG_W-1:0] reg_tag  [NREGS];
  logic [15:0]      reg_val  [NREGS];

  // Set for one cycle after a taken branch; the IB head is stale then.
  logic flush_hold;

  logic [15:0] head_pc;
  logic [15:0] head_inst;
  logic [3:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rt;
  logic [7:0]  imm8;
  logic        head_valid;
  logic        jeq_ready;
  logic        jeq_equal;
  logic [15:0] jeq_target;
  logic        mov_write;

  assign head_pc    = ib_data_out[31:16];
  assign head_inst  = ib_data_out[15:0];
  assign op         = head_inst[15:12];
  assign ra         = head_inst[11:8];
  assign rb         = head_inst[7:4];
  assign rt         = head_inst[3:0];
  assign imm8       = head_inst[11:4];
  assign head_valid = !ib_empty && !flush_hold;
  assign jeq_ready  = !op_a_busy && !op_b_busy;
  assign jeq_equal  = (op_a_val == op_b_val);
  assign jeq_target = head_pc + 16'd1 + {{12{rt[3]}}, rt};
  assign halted     = (state == S_HALT);

  // Read both source operands, forwarding a same-cycle CDB result as ready.
  always_comb begin
    op_a_busy = reg_busy[ra];
    op_a_tag  = reg_tag[ra];
    op_a_val  = reg_val[ra];
    op_b_busy = reg_busy[rb];
    op_b_tag  = reg_tag[rb];
    op_b_val  = reg_val[rb];
    if (cdb_valid && reg_busy[ra] && (reg_tag[ra] == cdb_tag)) begin
      op_a_busy = 1'b0;
      op_a_val  = cdb_data;
    end
    if (cdb_valid && reg_busy[rb] && (reg_tag[rb] == cdb_tag)) begin
      op_b_busy = 1'b0;
      op_b_val  = cdb_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: park on a jeq with a busy operand, stop for good on halt.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (head_valid) begin
          if (op == OP_JEQ && !jeq_ready) begin
            state_next = S_BR_WAIT;
          end else if (op == OP_HALT) begin
            state_next = S_HALT;
          end
        end
      end
      S_BR_WAIT: begin
        if (head_valid && jeq_ready) begin
          state_next = S_RUN;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  // Outputs: pop/issue/branch decisions from the state and the IB head.
  always_comb begin
    ib_pop        = 1'b0;
    ib_flush      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'd0;
    alu_issue     = 1'b0;
    ld_issue      = 1'b0;
    mov_write     = 1'b0;
    case (state)
      S_RUN: begin
        if (head_valid) begin
          case (op)
            OP_MOV: begin
              ib_pop    = 1'b1;
              mov_write = 1'b1;
            end
            OP_ADD: begin
              if (alu_free) begin
                ib_pop    = 1'b1;
                alu_issue = 1'b1;
              end
            end
            OP_LD: begin
              if (ld_free) begin
                ib_pop   = 1'b1;
                ld_issue = 1'b1;
              end
            end
            OP_JEQ: begin
              if (jeq_ready) begin
                ib_pop = 1'b1;
                if (jeq_equal) begin
                  branch_taken  = 1'b1;
                  ib_flush      = 1'b1;
                  branch_target = jeq_target;
                end
              end
            end
            default: begin
              ib_pop = 1'b1;
            end
          endcase
        end
      end
      S_BR_WAIT: begin
        if (head_valid && jeq_ready) begin
          ib_pop = 1'b1;
          if (jeq_equal) begin
            branch_taken  = 1'b1;
            ib_flush      = 1'b1;
            branch_target = jeq_target;
          end
        end
      end
      default: begin
        ib_pop = 1'b0;
      end
    endcase
  end

  // Remember a taken branch so the following cycle does not pop stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_hold <= 1'b0;
    end else begin
      flush_hold <= branch_taken;
    end
  end

  // Register file update: CDB retires tags first, then rename/mov of rt wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        reg_busy[i] <= 1'b0;
        reg_tag[i]  <= '0;
        reg_val[i]  <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (cdb_valid && reg_busy[i] && (reg_tag[i] == cdb_tag)) begin
          reg_busy[i] <= 1'b0;
          reg_val[i]  <= cdb_data;
        end
      end
      if (alu_issue) begin
        reg_busy[rt] <= 1'b1;
        reg_tag[rt]  <= alu_free_tag;
      end else if (ld_issue) begin
        reg_busy[rt] <= 1'b1;
        reg_tag[rt]  <= ld_free_tag;
      end else if (mov_write) begin
        reg_busy[rt] <= 1'b0;
        reg_val[rt]  <= {8'd0, imm8};
      end
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: directed scenarios for the dispatch stage.
module tb_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ib_empty;
  logic [31:0] ib_data_out;
  logic        ib_pop;
  logic        ib_flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        alu_free;
  logic [3:0]  alu_free_tag;
  logic        alu_issue;
  logic        ld_free;
  logic [3:0]  ld_free_tag;
  logic        ld_issue;
  logic        op_a_busy;
  logic [3:0]  op_a_tag;
  logic [15:0] op_a_val;
  logic        op_b_busy;
  logic [3:0]  op_b_tag;
  logic [15:0] op_b_val;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        halted;

  int checks = 0;
  int failures = 0;

  dispatch #(.TAG_W(4), .NREGS(16)) dut (
    .clk(clk), .rst(rst),
    .ib_empty(ib_empty), .ib_data_out(ib_data_out),
    .ib_pop(ib_pop), .ib_flush(ib_flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .alu_free(alu_free), .alu_free_tag(alu_free_tag), .alu_issue(alu_issue),
    .ld_free(ld_free), .ld_free_tag(ld_free_tag), .ld_issue(ld_issue),
    .op_a_busy(op_a_busy), .op_a_tag(op_a_tag), .op_a_val(op_a_val),
    .op_b_busy(op_b_busy), .op_b_tag(op_b_tag), .op_b_val(op_b_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [15:0] pc, input logic [3:0] op,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] t);
    return {pc, op, a, b, t};
  endfunction

  function automatic logic [31:0] mk_mov(input logic [3:0] t, input logic [7:0] imm);
    return {16'h0000, 4'h0, imm, t};
  endfunction

  task automatic idle();
    ib_empty     = 1'b1;
    ib_data_out  = 32'd0;
    alu_free     = 1'b0;
    alu_free_tag = 4'd0;
    ld_free      = 1'b0;
    ld_free_tag  = 4'd0;
    cdb_valid    = 1'b0;
    cdb_tag      = 4'd0;
    cdb_data     = 16'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  // Show registers a and b on the operand outputs without popping anything.
  task automatic probe(input logic [3:0] a, input logic [3:0] b);
    ib_empty    = 1'b1;
    ib_data_out = mk(16'h0, 4'h3, a, b, 4'h0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ib_pop !== 1'b0) begin failures++; $display("[TB] FAIL rst_pop got=%0b exp=0", ib_pop); end
    checks++; if (ib_flush !== 1'b0 || branch_taken !== 1'b0) begin failures++; $display("[TB] FAIL rst_flush got=%0b/%0b exp=0/0", ib_flush, branch_taken); end
    checks++; if (alu_issue !== 1'b0 || ld_issue !== 1'b0) begin failures++; $display("[TB] FAIL rst_issue got=%0b/%0b exp=0/0", alu_issue, ld_issue); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL rst_halted got=%0b exp=0", halted); end
    checks++; if (branch_target !== 16'h0) begin failures++; $display("[TB] FAIL rst_target got=%h exp=0000", branch_target); end
    probe(4'd0, 4'd15);
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'h0 || op_b_busy !== 1'b0 || op_b_val !== 16'h0) begin
      failures++; $display("[TB] FAIL rst_regs got=%0b/%h %0b/%h exp=0/0000 0/0000", op_a_busy, op_a_val, op_b_busy, op_b_val); end
    rst = 1'b0;
    @(negedge clk);
    idle();
    ib_empty = 1'b1; ib_data_out = mk_mov(4'd1, 8'd5); #1;
    checks++; if (ib_pop !== 1'b0) begin failures++; $display("[TB] FAIL empty_pop got=%0b exp=0", ib_pop); end
    next_cycle();
  endtask

  task automatic test_mov_add();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd1, 8'd5); #1;
    checks++; if (ib_pop !== 1'b1 || alu_issue !== 1'b0) begin failures++; $display("[TB] FAIL mov1 got=pop%0b/alu%0b exp=1/0", ib_pop, alu_issue); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd2, 8'd7); #1;
    checks++; if (ib_pop !== 1'b1) begin failures++; $display("[TB] FAIL mov2_pop got=%0b exp=1", ib_pop); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd1, 4'd2, 4'd3);
    alu_free = 1'b1; alu_free_tag = 4'd2; #1;
    checks++; if (alu_issue !== 1'b1 || ib_pop !== 1'b1 || ld_issue !== 1'b0) begin failures++; $display("[TB] FAIL add_issue got=alu%0b/pop%0b/ld%0b exp=1/1/0", alu_issue, ib_pop, ld_issue); end
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd5) begin failures++; $display("[TB] FAIL add_a got=%0b/%0d exp=0/5", op_a_busy, op_a_val); end
    checks++; if (op_b_busy !== 1'b0 || op_b_val !== 16'd7) begin failures++; $display("[TB] FAIL add_b got=%0b/%0d exp=0/7", op_b_busy, op_b_val); end
    next_cycle();
    probe(4'd3, 4'd1);
    checks++; if (op_a_busy !== 1'b1 || op_a_tag !== 4'd2) begin failures++; $display("[TB] FAIL r3_renamed got=%0b/%0d exp=1/2", op_a_busy, op_a_tag); end
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 16'd12;
    next_cycle();
    probe(4'd3, 4'd1);
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd12) begin failures++; $display("[TB] FAIL r3_cdb got=%0b/%0d exp=0/12", op_a_busy, op_a_val); end
    next_cycle();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd1, 4'd2, 4'd5); alu_free = 1'b0; #1;
      checks++; if (ib_pop !== 1'b0 || alu_issue !== 1'b0) begin failures++; $display("[TB] FAIL stall%0d got=pop%0b/alu%0b exp=0/0", i, ib_pop, alu_issue); end
      next_cycle();
    end
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd1, 4'd2, 4'd5);
    alu_free = 1'b1; alu_free_tag = 4'd7; #1;
    checks++; if (ib_pop !== 1'b1 || alu_issue !== 1'b1) begin failures++; $display("[TB] FAIL stall_release got=pop%0b/alu%0b exp=1/1", ib_pop, alu_issue); end
    next_cycle();
    probe(4'd5, 4'd5);
    checks++; if (op_a_busy !== 1'b1 || op_a_tag !== 4'd7) begin failures++; $display("[TB] FAIL r5_renamed got=%0b/%0d exp=1/7", op_a_busy, op_a_tag); end
    next_cycle();
  endtask

  task automatic test_forward();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd2, 4'd2, 4'd1);
    alu_free = 1'b1; alu_free_tag = 4'd3; #1;
    checks++; if (alu_issue !== 1'b1) begin failures++; $display("[TB] FAIL r1_rename_issue got=%0b exp=1", alu_issue); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd1, 4'd1, 4'd4);
    alu_free = 1'b1; alu_free_tag = 4'd4;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 16'd9; #1;
    checks++; if (alu_issue !== 1'b1 || ib_pop !== 1'b1) begin failures++; $display("[TB] FAIL fwd_issue got=alu%0b/pop%0b exp=1/1", alu_issue, ib_pop); end
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd9 || op_b_busy !== 1'b0 || op_b_val !== 16'd9) begin
      failures++; $display("[TB] FAIL fwd_ops got=%0b/%0d %0b/%0d exp=0/9 0/9", op_a_busy, op_a_val, op_b_busy, op_b_val); end
    next_cycle();
    probe(4'd1, 4'd4);
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd9) begin failures++; $display("[TB] FAIL r1_after_cdb got=%0b/%0d exp=0/9", op_a_busy, op_a_val); end
    checks++; if (op_b_busy !== 1'b1 || op_b_tag !== 4'd4) begin failures++; $display("[TB] FAIL r4_renamed got=%0b/%0d exp=1/4", op_b_busy, op_b_tag); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h2, 4'd1, 4'd2, 4'd6);
    ld_free = 1'b0; alu_free = 1'b1; alu_free_tag = 4'd6; #1;
    checks++; if (ib_pop !== 1'b0 || ld_issue !== 1'b0 || alu_issue !== 1'b0) begin failures++; $display("[TB] FAIL ld_stall got=pop%0b/ld%0b/alu%0b exp=0/0/0", ib_pop, ld_issue, alu_issue); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h2, 4'd1, 4'd2, 4'd6);
    ld_free = 1'b1; ld_free_tag = 4'd8; #1;
    checks++; if (ib_pop !== 1'b1 || ld_issue !== 1'b1 || alu_issue !== 1'b0) begin failures++; $display("[TB] FAIL ld_issue got=pop%0b/ld%0b/alu%0b exp=1/1/0", ib_pop, ld_issue, alu_issue); end
    checks++; if (op_a_val !== 16'd9 || op_b_val !== 16'd7) begin failures++; $display("[TB] FAIL ld_ops got=%0d/%0d exp=9/7", op_a_val, op_b_val); end
    next_cycle();
    probe(4'd6, 4'd6);
    checks++; if (op_a_busy !== 1'b1 || op_a_tag !== 4'd8) begin failures++; $display("[TB] FAIL r6_renamed got=%0b/%0d exp=1/8", op_a_busy, op_a_tag); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd2, 4'd2, 4'd4);
    alu_free = 1'b1; alu_free_tag = 4'd5;
    cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 16'd33; #1;
    next_cycle();
    probe(4'd4, 4'd4);
    checks++; if (op_a_busy !== 1'b1 || op_a_tag !== 4'd5) begin failures++; $display("[TB] FAIL rename_beats_cdb got=%0b/%0d exp=1/5", op_a_busy, op_a_tag); end
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 16'd20;
    next_cycle();
    probe(4'd4, 4'd4);
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd20) begin failures++; $display("[TB] FAIL r4_cdb got=%0b/%0d exp=0/20", op_a_busy, op_a_val); end
    next_cycle();
  endtask

  task automatic test_branch_taken();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd1, 8'd4); #1;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd2, 8'd4); #1;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0010, 4'h6, 4'd1, 4'd2, 4'd2); #1;
    checks++; if (ib_pop !== 1'b1 || branch_taken !== 1'b1 || ib_flush !== 1'b1) begin failures++; $display("[TB] FAIL jeq_taken got=pop%0b/tk%0b/fl%0b exp=1/1/1", ib_pop, branch_taken, ib_flush); end
    checks++; if (branch_target !== 16'h0013) begin failures++; $display("[TB] FAIL jeq_target got=%h exp=0013", branch_target); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd9, 8'd1); #1;
    checks++; if (ib_pop !== 1'b0 || ib_flush !== 1'b0 || branch_taken !== 1'b0) begin failures++; $display("[TB] FAIL post_flush got=pop%0b/fl%0b/tk%0b exp=0/0/0", ib_pop, ib_flush, branch_taken); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd9, 8'd1); #1;
    checks++; if (ib_pop !== 1'b1) begin failures++; $display("[TB] FAIL post_flush_resume got=%0b exp=1", ib_pop); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0020, 4'h6, 4'd1, 4'd2, 4'hF); #1;
    checks++; if (branch_taken !== 1'b1 || branch_target !== 16'h0020) begin failures++; $display("[TB] FAIL jeq_neg got=%0b/%h exp=1/0020", branch_taken, branch_target); end
    next_cycle();
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0050, 4'h6, 4'd1, 4'd3, 4'd2); #1;
    checks++; if (ib_pop !== 1'b1 || branch_taken !== 1'b0 || ib_flush !== 1'b0) begin failures++; $display("[TB] FAIL jeq_not_taken got=pop%0b/tk%0b/fl%0b exp=1/0/0", ib_pop, branch_taken, ib_flush); end
    next_cycle();
  endtask

  task automatic test_branch_wait();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd2, 4'd2, 4'd1);
    alu_free = 1'b1; alu_free_tag = 4'd5; #1;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0030, 4'h6, 4'd1, 4'd2, 4'd3); #1;
    checks++; if (ib_pop !== 1'b0 || branch_taken !== 1'b0) begin failures++; $display("[TB] FAIL jeq_busy got=pop%0b/tk%0b exp=0/0", ib_pop, branch_taken); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0030, 4'h6, 4'd1, 4'd2, 4'd3); #1;
    checks++; if (ib_pop !== 1'b0) begin failures++; $display("[TB] FAIL br_wait_hold got=%0b exp=0", ib_pop); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0030, 4'h6, 4'd1, 4'd2, 4'd3);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 16'd6; #1;
    checks++; if (ib_pop !== 1'b1 || branch_taken !== 1'b0 || ib_flush !== 1'b0) begin failures++; $display("[TB] FAIL br_wait_resolve got=pop%0b/tk%0b/fl%0b exp=1/0/0", ib_pop, branch_taken, ib_flush); end
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd6) begin failures++; $display("[TB] FAIL br_wait_fwd got=%0b/%0d exp=0/6", op_a_busy, op_a_val); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd10, 8'd3); #1;
    checks++; if (ib_pop !== 1'b1) begin failures++; $display("[TB] FAIL back_to_run got=%0b exp=1", ib_pop); end
    next_cycle();
  endtask

  task automatic test_halt();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd2, 4'd2, 4'd7);
    alu_free = 1'b1; alu_free_tag = 4'd9; #1;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'hF, 4'd0, 4'd0, 4'd0); #1;
    checks++; if (ib_pop !== 1'b1 || halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_pop got=pop%0b/h%0b exp=1/0", ib_pop, halted); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd2, 4'd2, 4'd8);
      alu_free = 1'b1; alu_free_tag = 4'd1;
      if (i == 1) begin cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'd55; end
      #1;
      checks++; if (halted !== 1'b1 || ib_pop !== 1'b0 || alu_issue !== 1'b0) begin failures++; $display("[TB] FAIL halted%0d got=h%0b/pop%0b/alu%0b exp=1/0/0", i, halted, ib_pop, alu_issue); end
      next_cycle();
    end
    probe(4'd7, 4'd8);
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd55) begin failures++; $display("[TB] FAIL halt_cdb got=%0b/%0d exp=0/55", op_a_busy, op_a_val); end
    checks++; if (op_b_busy !== 1'b0) begin failures++; $display("[TB] FAIL halt_no_rename got=%0b exp=0", op_b_busy); end
  endtask

  task automatic test_reset_mid_wait();
    rst = 1'b1; #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL rst_unhalt got=%0b exp=0", halted); end
    rst = 1'b0;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk_mov(4'd2, 8'd4); #1;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0, 4'h1, 4'd2, 4'd2, 4'd1);
    alu_free = 1'b1; alu_free_tag = 4'd2; #1;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0040, 4'h6, 4'd1, 4'd2, 4'd1); #1;
    checks++; if (ib_pop !== 1'b0) begin failures++; $display("[TB] FAIL wait2_enter got=%0b exp=0", ib_pop); end
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0040, 4'h6, 4'd1, 4'd2, 4'd1); #1;
    rst = 1'b1;
    probe(4'd1, 4'd2);
    checks++; if (op_a_busy !== 1'b0 || op_a_val !== 16'd0 || op_b_busy !== 1'b0 || op_b_val !== 16'd0) begin
      failures++; $display("[TB] FAIL rst_mid_wait got=%0b/%0d %0b/%0d exp=0/0 0/0", op_a_busy, op_a_val, op_b_busy, op_b_val); end
    rst = 1'b0;
    next_cycle();
    ib_empty = 1'b0; ib_data_out = mk(16'h0040, 4'h6, 4'd1, 4'd2, 4'd1); #1;
    checks++; if (ib_pop !== 1'b1 || branch_taken !== 1'b1 || branch_target !== 16'h0042) begin
      failures++; $display("[TB] FAIL rst_then_run got=pop%0b/tk%0b/%h exp=1/1/0042", ib_pop, branch_taken, branch_target); end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    test_reset();
    test_mov_add();
    test_stall();
    test_forward();
    test_branch_taken();
    test_branch_wait();
    test_halt();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
